// File: rtl/acc_writeback.sv
`default_nettype none
// ============================================================================
// Module      : acc_writeback
// Description : Captures a completed accumulator row and requantizes each
//               element with optional ReLU, a rounding arithmetic right shift
//               and signed saturation. It then writes the elements to the
//               unified buffer, one per cycle, at consecutive addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_writeback #(
    parameter int N      = 2,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                row_valid,
    input  logic [N*ACC_W-1:0]  row_data,
    input  logic                relu_en,
    input  logic [4:0]          shift,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                row_ready,
    output logic                busy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [OUT_W-1:0]    wr_data,
    input  logic                wr_ready,
    output logic                done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    // Saturation bounds, expressed in the widened ACC_W+1 arithmetic domain
    localparam logic signed [ACC_W:0] c_sat_max = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] c_sat_min = -c_sat_max - (ACC_W+1)'(1);

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [N*ACC_W-1:0]  r_row;
    logic                r_relu;
    logic [4:0]          r_shift;
    logic [ADDR_W-1:0]   r_base;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [OUT_W-1:0]    r_wr_data;
    logic                r_done;

    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_wr_en_nxt;
    logic [ADDR_W-1:0]   w_wr_addr_nxt;
    logic [OUT_W-1:0]    w_wr_data_nxt;
    logic                w_done_nxt;
    logic                w_capture;

    logic [ACC_W-1:0]    w_elem [N];

    // Split the captured row into individually addressable elements
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_elem[gi] = r_row[gi*ACC_W +: ACC_W];
        end
    endgenerate

    // Requantize one element. One extra bit of headroom keeps the rounding
    // add from overflowing at the positive extreme of the accumulator range.
    function automatic logic [OUT_W-1:0] f_quant(
        input logic [ACC_W-1:0] x,
        input logic             relu,
        input logic [4:0]       sh
    );
        logic signed [ACC_W:0] v;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] y;
        v = {x[ACC_W-1], x};
        if (relu && v[ACC_W]) begin
            v = '0;
        end
        if (sh != 5'd0) begin
            rnd = (ACC_W+1)'(1) << (sh - 5'd1);
            y   = (v + rnd) >>> sh;
        end else begin
            y = v;
        end
        if (y > c_sat_max) begin
            f_quant = c_sat_max[OUT_W-1:0];
        end else if (y < c_sat_min) begin
            f_quant = c_sat_min[OUT_W-1:0];
        end else begin
            f_quant = y[OUT_W-1:0];
        end
    endfunction

    assign w_idx_inc = r_idx + IDX_W'(1);

    // Next-state and next-output decode; write port values are precomputed so
    // every output comes straight from a register.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_wr_en_nxt   = r_wr_en;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            c_idle: begin
                if (row_valid) begin
                    w_capture     = 1'b1;
                    w_state_nxt   = c_write;
                    w_idx_nxt     = '0;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = base_addr;
                    w_wr_data_nxt = f_quant(row_data[ACC_W-1:0], relu_en, shift);
                end
            end
            c_write: begin
                if (wr_ready) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = c_done;
                        w_wr_en_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_wr_addr_nxt = r_base + ADDR_W'(w_idx_inc);
                        w_wr_data_nxt = f_quant(w_elem[w_idx_inc], r_relu, r_shift);
                    end
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
                w_wr_en_nxt = 1'b0;
            end
        endcase
    end

    // Control and write-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Row and per-row settings are frozen at acceptance for the whole row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row   <= '0;
            r_relu  <= 1'b0;
            r_shift <= '0;
            r_base  <= '0;
        end else if (w_capture) begin
            r_row   <= row_data;
            r_relu  <= relu_en;
            r_shift <= shift;
            r_base  <= base_addr;
        end
    end

    assign row_ready = (r_state == c_idle);
    assign busy      = (r_state != c_idle);
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_acc_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_writeback
// Description : Self-checking bench for acc_writeback with directed and
//               randomized rows against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_writeback;

    localparam int N      = 2;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               row_valid;
    logic [N*ACC_W-1:0] row_data;
    logic               relu_en;
    logic [4:0]         shift;
    logic [ADDR_W-1:0]  base_addr;
    logic               row_ready;
    logic               busy;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [OUT_W-1:0]   wr_data;
    logic               wr_ready;
    logic               done;

    int checks = 0;
    int errors = 0;

    acc_writeback #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_valid (row_valid),
        .row_data  (row_data),
        .relu_en   (relu_en),
        .shift     (shift),
        .base_addr (base_addr),
        .row_ready (row_ready),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference quantizer using wide signed integer arithmetic
    function automatic logic [7:0] q_model(input longint x, input bit relu, input int sh);
        longint v;
        logic [63:0] bits;
        v = x;
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        bits = v;
        return bits[7:0];
    endfunction

    // One cycle of an element being presented on the write port
    task automatic check_write(input logic [7:0] a, input logic [7:0] d);
        chk("wr_en",     wr_en,     1);
        chk("wr_addr",   wr_addr,   a);
        chk("wr_data",   wr_data,   d);
        chk("busy",      busy,      1);
        chk("row_ready", row_ready, 0);
        chk("done",      done,      0);
    endtask

    // Send one row from IDLE and follow it to IDLE again, cycle by cycle
    task automatic run_row(input logic [31:0] e0, input logic [31:0] e1,
                           input bit relu, input logic [4:0] sh,
                           input logic [7:0] base, input int stall, input bit inject);
        logic [7:0] exp_d [2];
        logic [7:0] exp_a [2];
        exp_d[0] = q_model(longint'($signed(e0)), relu, int'(sh));
        exp_d[1] = q_model(longint'($signed(e1)), relu, int'(sh));
        exp_a[0] = base;
        exp_a[1] = base + 8'd1;

        chk("idle_ready", row_ready, 1);
        row_valid = 1'b1;
        row_data  = {e1, e0};
        relu_en   = relu;
        shift     = sh;
        base_addr = base;
        wr_ready  = 1'b1;
        @(negedge clk);
        // Accepted; changing the inputs now must not affect the row
        row_valid = 1'b0;
        row_data  = {$urandom, $urandom};
        relu_en   = ~relu;
        shift     = 5'($urandom);
        base_addr = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                for (int s = 0; s < stall; s++) begin
                    check_write(exp_a[k], exp_d[k]);
                    wr_ready = 1'b0;
                    if (inject) begin
                        row_valid = 1'b1;
                        row_data  = {$urandom, $urandom};
                    end
                    @(negedge clk);
                end
            end
            check_write(exp_a[k], exp_d[k]);
            wr_ready  = 1'b1;
            row_valid = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", done,      1);
        chk("done_wr_en", wr_en,     0);
        chk("done_busy",  busy,      1);
        chk("done_ready", row_ready, 0);
        wr_ready = 1'($urandom);
        @(negedge clk);
        chk("done_end",   done,      0);
        chk("back_ready", row_ready, 1);
        chk("back_busy",  busy,      0);
        chk("back_wr_en", wr_en,     0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        row_valid = 1'b0;
        row_data  = '0;
        relu_en   = 1'b0;
        shift     = '0;
        base_addr = '0;
        wr_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row_ready", row_ready, 1);
        chk("rst_busy",      busy,      0);
        chk("rst_wr_en",     wr_en,     0);
        chk("rst_done",      done,      0);
        chk("rst_wr_addr",   wr_addr,   0);
        chk("rst_wr_data",   wr_data,   0);
        reset = 1'b0;
        @(negedge clk);

        // Saturation
        run_row(32'd300, -32'sd5, 1'b0, 5'd0, 8'h10, 0, 1'b0);
        // ReLU
        run_row(-32'sd1000, 32'd64, 1'b1, 5'd2, 8'h00, 0, 1'b0);
        // Rounding
        run_row(32'd6, -32'sd6, 1'b0, 5'd2, 8'h20, 0, 1'b0);
        run_row(32'd5, -32'sd7, 1'b0, 5'd2, 8'h30, 0, 1'b0);
        run_row(32'h7FFFFFFF, 32'h80000000, 1'b0, 5'd1, 8'h40, 0, 1'b0);
        run_row(32'h7FFFFFFF, 32'h80000000, 1'b0, 5'd31, 8'h41, 0, 1'b0);
        // Backpressure with a competing row_valid during the stall
        run_row(32'd1234, -32'sd4321, 1'b0, 5'd4, 8'h50, 3, 1'b1);
        // Address wrap
        run_row(32'd1, 32'd2, 1'b0, 5'd0, 8'hFF, 0, 1'b0);

        // Reset in the middle of a stalled row
        row_valid = 1'b1;
        row_data  = {32'd7, 32'd9};
        base_addr = 8'h60;
        shift     = 5'd0;
        relu_en   = 1'b0;
        wr_ready  = 1'b0;
        @(negedge clk);
        row_valid = 1'b0;
        chk("mid_wr_en", wr_en, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", wr_en,     0);
        chk("mid_rst_ready", row_ready, 1);
        chk("mid_rst_done",  done,      0);
        reset    = 1'b0;
        wr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_no_done",  done,  0);
            chk("mid_no_write", wr_en, 0);
        end

        // Randomized rows
        for (int r = 0; r < 24; r++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = 32'($signed($urandom) >>> $urandom_range(0, 31));
            b = 32'($signed($urandom) >>> $urandom_range(0, 31));
            run_row(a, b, 1'($urandom), 5'($urandom_range(0, 31)),
                    8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_writeback.md
Name: acc_writeback

Overview:
- Downstream consumer of the accumulator stage.
- Captures a completed row of 32-bit signed accumulator results when the accumulator signals full.
- Applies optional ReLU, then a rounding arithmetic right shift, then saturation to signed 8-bit.
- Writes the row into the unified buffer one element per cycle over a valid/ready write port at consecutive addresses.

Parameters:
- N, 2, elements per row (matches accumulator depth).
- ACC_W, 32, accumulator element width (signed).
- OUT_W, 8, output element width (signed, saturated).
- ADDR_W, 8, unified buffer address width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- row_valid  in  1  accumulator row complete (driven from accumulator full).
- row_data  in  N*ACC_W  row; element i at bits [i*ACC_W +: ACC_W], two's complement.
- relu_en  in  1  clamp negative elements to 0 before shifting.
- shift  in  5  requantization right-shift amount, 0..31.
- base_addr  in  ADDR_W  buffer address for element 0.
- row_ready  out  1  high only in IDLE; row is accepted on row_valid && row_ready.
- busy  out  1  high in WRITE and DONE.
- wr_en  out  1  write request to the unified buffer.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  OUT_W  write data.
- wr_ready  in  1  buffer accepts the write on wr_en && wr_ready.
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, idx=0. Outputs: row_ready=1, busy=0, wr_en=0, wr_addr=0, wr_data=0, done=0.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - On row_valid, register row_data, relu_en, shift and base_addr; set idx=0; go to WRITE.
  - Without row_valid, stay in IDLE.
- WRITE:
  - wr_en=1, wr_addr=(base_addr+idx) mod 2^ADDR_W, wr_data=q(elem[idx]).
  - On wr_ready: if idx==N-1 go to DONE, else idx+1.
  - If wr_ready is low: wr_en, wr_addr and wr_data hold stable, with no other state change.
- DONE: done=1 for exactly one cycle, row_ready=0; then IDLE.
- Latency: with wr_ready tied high and a row accepted at edge T, elements are written at cycles T+1..T+N, done is high at T+N+1, and row_ready returns at T+N+2.
- Registered inputs: row_valid and input changes during WRITE/DONE are ignored. The captured row, shift, relu_en and base_addr stay fixed for the whole row. The upstream holds full until row_ready.
- Quantizer q(x), evaluated in ACC_W+1 bits:
  - If relu_en and x<0, then x=0.
  - If shift>0: y=(x + 2^(shift-1)) >>> shift (arithmetic, round half up). Otherwise y=x.
  - Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The rounding add must not overflow: 0x7FFFFFFF with shift=1 gives 0x40000000, which saturates to 127.
- Address wrap: wr_addr wraps modulo 2^ADDR_W with no error indication.
- Reset mid-row: the row is abandoned. wr_en=0 and done=0 from the next cycle; state=IDLE; no partial done pulse.
- No combinational path from row_valid or wr_ready to any output; all outputs are registered.

Test Plan:
- Reset: assert reset for 2 cycles -> row_ready=1, busy=0, wr_en=0, done=0, wr_addr=0, wr_data=0.
- Saturation: row [300, -5], shift=0, relu_en=0, base_addr=0x10, wr_ready=1 -> writes (0x10, 0x7F) then (0x11, 0xFB); done pulses 3 cycles after accept; row_ready high one cycle later.
- ReLU: row [-1000, 64], relu_en=1, shift=2, base_addr=0 -> writes (0x00, 0x00) then (0x01, 0x10).
- Rounding: row [6, -6], shift=2 -> 0x02 and 0xFF. Row [5, -7], shift=2 -> 0x01 and 0xFE. Row [0x7FFFFFFF, 0x80000000], shift=1 -> 0x7F and 0x80.
- Backpressure and ignored input: wr_ready low for 3 cycles on element 0 -> wr_en/wr_addr/wr_data stable across those cycles and done delayed by exactly 3 cycles. A row_valid with new data while busy -> no capture; written data comes from the original row.
- Wrap and reset: base_addr=0xFF, N=2 -> addresses 0xFF then 0x00. Separately, assert reset while in WRITE with wr_ready low -> next cycle wr_en=0, row_ready=1, and done never pulses for that row.
